gonso_sched: RTL
================

# gonso_sched

Two-requester scheduler for the 20-bit gonso datapath (the Honzales compute core). It arbitrates operand requests from two independent masters, one issue per cycle, and drives the shared datapath input. It tracks each in-flight operation with a tag pipeline of fixed depth and steers each result back to the requester that issued it. It sits between the wishbone register front-end (requester 0), a second on-chip requester (requester 1) and the datapath instance.

## Interface
- DW, 20, operand/result width
- LAT, 2, cycles from dp_input update to valid dp_output (≥1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  grant enable; low blocks new issues, in-flight ops still complete
- cfg_rr  in  1  0: fixed priority (req0 wins), 1: round-robin
- req0_valid / req1_valid  in  1  operand offered
- req0_ready / req1_ready  out  1  grant, combinational
- req0_data / req1_data  in  DW  operand
- rsp0_valid / rsp1_valid  out  1  one-cycle result strobe, no backpressure
- rsp0_data / rsp1_data  out  DW  result, held until next strobe for that requester
- dp_input  out  DW  registered operand to datapath
- dp_output  in  DW  datapath result
- busy  out  1  any op in flight
- done_cnt0 / done_cnt1  out  16  completed-op counters per requester

## Operation
- Grant: reqN_ready = enable && !rst && arbiter selects N; at most one ready high per cycle; ready never depends on the other requester's ready.
- Fixed priority: req0 granted whenever req0_valid; req1 only when req0_valid low.
- Round-robin: last-grant pointer `last`; both valid → grant !last; single valid → grant it. `last` updates only on a completed handshake. Reset value last=1 (req0 wins first contention).
- cfg_rr changes take effect the next cycle; `last` retained.
- Issue (handshake in cycle c): dp_input <= reqN_data at edge ending c; tag {v=1,id=N} enters stage 0 of the LAT-deep tag shift register. No issue: tag stage 0 gets v=0, dp_input holds its value.
- Retire: tag at stage LAT-1 valid with id N → at edge ending cycle c+LAT capture dp_output into rspN_data, pulse rspN_valid, done_cntN += 1 (wraps 0xFFFF→0x0000).
- busy = OR of all tag valid bits.
- Back-to-back issues every cycle supported; results return in issue order.

## Timing
- Handshake cycle c → dp_input new from c+1 → rspN_valid high in cycle c+LAT+1 for exactly one cycle.
- enable falling in cycle c: no handshake in c; ops issued before c still retire on schedule.
- Simultaneous retire for N and issue by N in the same cycle: both happen; no conflict.
- Reset values: req*_ready 0, dp_input 0, rsp*_valid 0, rsp*_data 0, done_cnt* 0, busy 0, all tags invalid, last=1.
- Reset mid-operation: all in-flight tags discarded; no rsp*_valid after rst deasserts for any pre-reset issue.

## Structure
- Package gonso_sched_pkg: DW default, req_id_t (1 bit), tag_t struct {valid, id}, RR reset constant.
- Sub-module gonso_sched_arb: 2-way fixed/round-robin arbiter holding `last`; top holds tag pipeline, dp_input reg, response regs, counters.

## Test plan
- Single op: LAT=2, req0 data 0x00005 at cycle 10 → dp_input 0x00005 at 11, rsp0_valid only in cycle 13 with dp_output value, done_cnt0=1.
- Contention fixed: cfg_rr=0, both valid 4 cycles → four req0 grants, req1_ready never high.
- Contention RR: cfg_rr=1, both valid 4 cycles after reset → grants 0,1,0,1; rsp strobes 0,1,0,1 from cycle c+LAT+1.
- Enable gate: drop enable with 2 ops in flight → no new ready; both rsp strobes still arrive; busy falls after last.
- Reset mid-flight: assert rst 1 cycle after issue → no rsp*_valid ever; all outputs at reset values.
- Counter wrap: preload via 65536 req1 ops → done_cnt1 returns to 0x0000, done_cnt0 stays 0.

Source files
------------

// File: rtl/gonso_sched_pkg.sv
// Shared types and constants for the two-requester gonso datapath scheduler.
// The tag carries the requester id alongside each operation in flight.
package gonso_sched_pkg;

  localparam int DW_DEF  = 20;
  localparam int LAT_DEF = 2;

  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Pointer value after reset: req0 wins the first contention.
  localparam req_id_t RR_LAST_RST = REQ1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: REQ0};

  function automatic logic tag_hit(input tag_t t, input req_id_t n);
    return t.valid && (t.id == n);
  endfunction

endpackage

// File: rtl/gonso_sched_arb.sv
// Two-way arbiter with fixed priority or round-robin selection.
// Grants are combinational; the last-grant pointer moves only on a handshake.
module gonso_sched_arb
  import gonso_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic cfg_rr,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic gnt0,
  output logic gnt1
);

  req_id_t last_q, last_d;
  logic    pick0, pick1;
  logic    allow;

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (!cfg_rr || (last_q == REQ1)) begin
        pick0 = 1'b1;
      end else begin
        pick1 = 1'b1;
      end
    end else begin
      pick0 = req0_valid;
      pick1 = req1_valid;
    end
  end

  always_comb begin
    allow = enable && !rst;
    gnt0  = allow && pick0;
    gnt1  = allow && pick1;
  end

  // A grant always coincides with valid, so a grant is a completed handshake.
  always_comb begin
    last_d = last_q;
    if (gnt0) begin
      last_d = REQ0;
    end else if (gnt1) begin
      last_d = REQ1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= RR_LAST_RST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/gonso_sched.sv
// Issues operands from two requesters into the shared datapath and steers
// each result back to its issuer using a fixed-depth tag pipeline.
module gonso_sched
  import gonso_sched_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          cfg_rr,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic [DW-1:0] dp_input,
  input  logic [DW-1:0] dp_output,
  output logic          busy,
  output logic [15:0]   done_cnt0,
  output logic [15:0]   done_cnt1
);

  logic gnt0, gnt1;
  logic issue0, issue1;

  gonso_sched_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_rr     (cfg_rr),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign issue0     = req0_valid && gnt0;
  assign issue1     = req1_valid && gnt1;

  tag_t          tag_q [LAT];
  tag_t          tag_d [LAT];
  logic [DW-1:0] dp_input_q, dp_input_d;
  logic          rsp0_valid_q, rsp0_valid_d;
  logic          rsp1_valid_q, rsp1_valid_d;
  logic [DW-1:0] rsp0_data_q, rsp0_data_d;
  logic [DW-1:0] rsp1_data_q, rsp1_data_d;
  logic [15:0]   cnt0_q, cnt0_d;
  logic [15:0]   cnt1_q, cnt1_d;
  logic          retire0, retire1;
  logic          busy_c;

  always_comb begin
    tag_d[0]   = TAG_IDLE;
    dp_input_d = dp_input_q;
    if (issue0) begin
      tag_d[0]   = '{valid: 1'b1, id: REQ0};
      dp_input_d = req0_data;
    end else if (issue1) begin
      tag_d[0]   = '{valid: 1'b1, id: REQ1};
      dp_input_d = req1_data;
    end
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // The oldest stage lines up with the datapath result for that issue.
  always_comb begin
    retire0      = tag_hit(tag_q[LAT-1], REQ0);
    retire1      = tag_hit(tag_q[LAT-1], REQ1);
    rsp0_valid_d = retire0;
    rsp1_valid_d = retire1;
    rsp0_data_d  = retire0 ? dp_output : rsp0_data_q;
    rsp1_data_d  = retire1 ? dp_output : rsp1_data_q;
    cnt0_d       = cnt0_q + {15'd0, retire0};
    cnt1_d       = cnt1_q + {15'd0, retire1};
  end

  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      busy_c = busy_c | tag_q[i].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= TAG_IDLE;
      end
      dp_input_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
      dp_input_q   <= dp_input_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign dp_input   = dp_input_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign busy       = busy_c;
  assign done_cnt0  = cnt0_q;
  assign done_cnt1  = cnt1_q;

endmodule
